// File: rtl/bird.sv
// bird: vertical-motion engine for the player sprite; integrates gravity
// and flap impulses on a divided physics tick and drives the sprite top y.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   enable     - 1 = physics runs, 0 = paused
//   jump       - flap request level, rising edge detected internally
//   state      - 0 = idle/menu, 1 = playing
//   fall_accel - gravity added to velocity per tick (0..3)
//   y_coord    - registered sprite top-edge y (0 = top of screen)
//
// Optional build macro BIRD_TERMINAL_VEL_EN: when defined, downward
// velocity is capped at MAX_FALL_VEL after the gravity add.

module bird #(
    parameter int TICK_DIV     = 833333,
    parameter int Y_START      = 240,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 464,
    parameter int JUMP_VEL     = 8,
    parameter int MAX_FALL_VEL = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       jump,
    input  logic       state,
    input  logic [1:0] fall_accel,
    output logic [9:0] y_coord
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [7:0] VEL_JUMP = 8'(-JUMP_VEL);
    localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

    logic [CW-1:0]      r_cnt;
    logic signed [7:0]  r_vel;
    logic [9:0]         r_y;
    logic               r_jump_d;
    logic               r_pend;

    logic               w_edge;
    logic               w_tick;
    logic               w_flap;
    logic signed [8:0]  w_sum;
    logic signed [7:0]  w_grav;
    logic signed [7:0]  w_vel_n;
    logic signed [11:0] w_y_n;

    assign w_edge = jump & ~r_jump_d;
    assign w_tick = (r_cnt == CNT_LAST);
    // An edge landing on the tick cycle still counts for this tick.
    assign w_flap = r_pend | w_edge;

    // 9-bit sum so the gravity add can saturate at +127 instead of wrapping.
    assign w_sum = $signed({r_vel[7], r_vel}) + $signed({7'd0, fall_accel});

    always_comb begin
        w_grav = (w_sum > 9'sd127) ? 8'sd127 : w_sum[7:0];
`ifdef BIRD_TERMINAL_VEL_EN
        if (w_grav > 8'(MAX_FALL_VEL)) begin
            w_grav = 8'(MAX_FALL_VEL);
        end
`endif
        w_vel_n = w_flap ? VEL_JUMP : w_grav;
    end

    assign w_y_n = $signed({2'b00, r_y}) + $signed({{4{w_vel_n[7]}}, w_vel_n});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_vel    <= '0;
            r_y      <= 10'(Y_START);
            r_jump_d <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_jump_d <= jump;
            if (!state) begin
                r_cnt  <= '0;
                r_vel  <= '0;
                r_y    <= 10'(Y_START);
                r_pend <= 1'b0;
            end else if (enable) begin
                if (w_tick) begin
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    // Hitting ceiling or floor kills the velocity.
                    if (w_y_n < YMIN_S) begin
                        r_y   <= 10'(Y_MIN);
                        r_vel <= '0;
                    end else if (w_y_n > YMAX_S) begin
                        r_y   <= 10'(Y_MAX);
                        r_vel <= '0;
                    end else begin
                        r_y   <= w_y_n[9:0];
                        r_vel <= w_vel_n;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_edge) begin
                        r_pend <= 1'b1;
                    end
                end
            end
        end
    end

    assign y_coord = r_y;

endmodule

// File: tb/tb_bird.sv
// tb_bird: randomized and directed checks of bird against a behavioural
// model; y_coord is compared every cycle plus literal pin points.

module tb_bird;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       jump = 1'b0;
    logic       state = 1'b0;
    logic [1:0] fall_accel = 2'd0;
    logic [9:0] y_coord;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model
    int m_y = 240;
    int m_vel = 0;
    int m_cnt = 0;
    bit m_pend = 1'b0;
    bit m_jd = 1'b0;
    int m_ticks = 0;

    bird #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .jump(jump),
        .state(state),
        .fall_accel(fall_accel),
        .y_coord(y_coord)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        bit e;
        bit f;
        int v;
        int ny;
        if (!rst) begin
            m_y = 240; m_vel = 0; m_cnt = 0; m_pend = 0; m_jd = 0;
        end else begin
            e = jump && !m_jd;
            if (!state) begin
                m_y = 240; m_vel = 0; m_cnt = 0; m_pend = 0;
            end else if (enable) begin
                if (m_cnt == TD - 1) begin
                    f = m_pend || e;
                    if (f) v = -8;
                    else begin
                        v = m_vel + int'(fall_accel);
                        if (v > 127) v = 127;
`ifdef BIRD_TERMINAL_VEL_EN
                        if (v > 12) v = 12;
`endif
                    end
                    ny = m_y + v;
                    if (ny < 0) begin m_y = 0; m_vel = 0; end
                    else if (ny > 464) begin m_y = 464; m_vel = 0; end
                    else begin m_y = ny; m_vel = v; end
                    m_cnt = 0;
                    m_pend = 0;
                    m_ticks++;
                end else begin
                    m_cnt++;
                    if (e) m_pend = 1;
                end
            end
            m_jd = jump;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("y_coord", int'(y_coord), m_y);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = m_ticks + n;
        budget = 50 * n;
        while (m_ticks < target && budget > 0) begin
            step();
            budget--;
        end
        if (m_ticks < target) begin
            errors++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", m_ticks, target);
        end
    endtask

    task automatic pulse_jump();
        jump = 1'b1;
        step();
        jump = 1'b0;
    endtask

    initial begin
        int ff_exp[4];
        int tv_exp[6];
        ff_exp = '{241, 243, 246, 250};
`ifdef BIRD_TERMINAL_VEL_EN
        tv_exp = '{3, 9, 18, 30, 42, 54};
`else
        tv_exp = '{3, 9, 18, 30, 45, 63};
`endif
        // Reset with arbitrary inputs
        step();
        rst = 1'b0;
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            state = 1'($urandom);
            enable = 1'($urandom);
            jump = 1'($urandom);
            fall_accel = 2'($urandom);
            step();
            check("reset_y", int'(y_coord), 240);
        end
        state = 0; enable = 1; jump = 0; fall_accel = 0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_y", int'(y_coord), 240);
        end

        // Free fall
        state = 1; fall_accel = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ticks(1);
            check("freefall_y", int'(y_coord), ff_exp[k]);
        end

        // Flap from y=250, vel=4
        pulse_jump();
        wait_ticks(1);
        check("flap_y", int'(y_coord), 242);
        wait_ticks(1);
        check("flap_next_y", int'(y_coord), 235);

        // Floor
        fall_accel = 3;
        wait_ticks(25);
        check("floor_y", int'(y_coord), 464);
        wait_ticks(3);
        check("floor_hold_y", int'(y_coord), 464);

        // Ceiling with a flap every tick
        state = 0;
        step();
        step();
        check("idle_return_y", int'(y_coord), 240);
        state = 1; fall_accel = 0;
        for (int k = 0; k < 32; k++) begin
            pulse_jump();
            wait_ticks(1);
        end
        check("ceiling_y", int'(y_coord), 0);
        wait_ticks(2);
        check("ceiling_vel0_y", int'(y_coord), 0);

        // Pause mid-fall
        fall_accel = 1;
        wait_ticks(5);
        check("prepause_y", int'(y_coord), 15);
        step();
        step();
        enable = 0;
        for (int i = 0; i < 40; i++) begin
            jump = (i % 4 == 1);
            step();
            check("pause_y", int'(y_coord), 15);
        end
        jump = 0;
        step();
        enable = 1;
        wait_ticks(1);
        check("resume_y", int'(y_coord), 21);

        // Terminal velocity from the ceiling
        for (int k = 0; k < 4; k++) begin
            pulse_jump();
            wait_ticks(1);
        end
        check("tv_start_y", int'(y_coord), 0);
        fall_accel = 3;
        for (int k = 0; k < 6; k++) begin
            wait_ticks(1);
            check("terminal_y", int'(y_coord), tv_exp[k]);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            state = ($urandom % 16) != 0;
            enable = ($urandom % 8) != 0;
            jump = ($urandom % 3) == 0;
            fall_accel = 2'($urandom);
            rst = ($urandom % 300) != 0;
            step();
            rst = 1'b1;
        end
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bird.md
Name: bird

Overview:
- Vertical-motion engine for the player sprite in the Flappy Bird game.
- Integrates velocity and gravity on a divided physics tick and handles flap (jump) requests.
- Drives the sprite's top-edge y coordinate to the renderer and collision logic.
- Sits between the game-state controller (state/enable/fall_accel) and the VGA draw/collision blocks.

Parameters:
TICK_DIV, 833333, clk cycles per physics tick (60 Hz at 50 MHz); minimum 2
Y_START, 240, reset/idle y position
Y_MIN, 0, ceiling (smallest legal y)
Y_MAX, 464, floor (largest legal y; screen height minus sprite height)
JUMP_VEL, 8, upward speed loaded on a flap, pixels/tick
MAX_FALL_VEL, 12, terminal downward speed, pixels/tick (used only with optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = physics runs; 0 = freeze (pause)
jump  input  1  flap request, level input, rising-edge detected internally
state  input  1  0 = idle/menu, 1 = playing
fall_accel  input  2  gravity added to velocity per tick, 0..3 px/tick²
y_coord  output  10  registered sprite top-edge y, 0 = top of screen

Behaviour:
- One clock; reset asynchronous, active-low. While rst=0: y_coord=Y_START, velocity=0, tick counter=0, jump_pending=0, jump_d=0.
- Internal state:
  - vel: 8-bit signed; negative = upward.
  - y: 10-bit unsigned, driven directly as y_coord.
  - cnt: tick counter.
  - jump_d: registered copy of jump.
  - jump_pending: flap latch.
- Idle (state=0):
  - Every clock, y←Y_START, vel←0, cnt←0, jump_pending←0.
  - y_coord reaches Y_START on the first clock edge after state falls.
- Playing (state=1, enable=1):
  - cnt counts 0..TICK_DIV-1 and wraps.
  - tick asserts for one cycle when cnt==TICK_DIV-1.
- Pause (state=1, enable=0):
  - cnt, vel, y hold.
  - jump edges are ignored and not latched; jump_pending holds its prior value.
- Jump edge:
  - edge = jump & ~jump_d, evaluated every clock.
  - When playing and enabled, edge sets jump_pending.
  - Multiple edges between ticks collapse into one flap.
- On a tick edge:
  - flap = jump_pending | edge. An edge coinciding with the tick counts for this tick.
  - vel_n = flap ? -JUMP_VEL : vel + fall_accel. The sum saturates at +127.
  - y_n = y + vel_n, computed in 12-bit signed using the new velocity.
  - If y_n < Y_MIN: y←Y_MIN, vel←0.
  - If y_n > Y_MAX: y←Y_MAX, vel←0.
  - Otherwise: y←y_n, vel←vel_n.
  - jump_pending←0.
  - y_coord changes only on tick edges (latency: same edge as tick).
- fall_accel=0 with no flap gives constant velocity.
- fall_accel is sampled only at the tick.
- Resting on floor: each tick recomputes vel=fall_accel; the clamp re-zeros it; y stays Y_MAX.
- Reset mid-flight returns to reset values immediately, independent of clk.
- state 0→1 starts from y=Y_START, vel=0, cnt=0. The first tick comes TICK_DIV cycles later.

Optional Feature:
- Macro BIRD_TERMINAL_VEL_EN.
- When defined: after the gravity add, positive vel_n is limited to MAX_FALL_VEL.
- When undefined: downward velocity is limited only by the +127 saturation.
- Flap behaviour is identical in both builds.

Test Plan:
- TICK_DIV=4 in all scenarios.
- Reset: rst=0 with any inputs → y_coord=240. Release rst with state=0 for 20 cycles → y_coord stays 240.
- Free fall: state=1, enable=1, fall_accel=1, jump=0 → y_coord after ticks 1,2,3,4 = 241, 243, 246, 250.
- Flap: at rest at y=250, vel=4, pulse jump for 1 cycle → next tick y=242 (vel -8). Following tick with fall_accel=1: y=235 (vel -7).
- Floor and ceiling:
  - fall_accel=3, no jump → y_coord saturates at 464 and stays there.
  - Repeated flaps each tick from y=10 → y reaches 0 and holds; vel=0 after clamp.
- Pause: enable=0 mid-fall for 40 cycles, including jump pulses → y_coord constant. Re-enable → motion resumes with the stored velocity, no flap applied.
- Terminal velocity:
  - BIRD_TERMINAL_VEL_EN defined, fall_accel=3 from y=0 → per-tick displacement caps at 12.
  - Undefined → displacement keeps growing (3, 6, 9, 12, 15, …) until the floor clamp.
